// File: rtl/onewire_slave.sv
// 1-Wire responder: reset/presence handshake, ROM command decode (READ/SKIP/MATCH)
// and reception of a DATA_BITS payload over the shared open-drain bus.
module onewire_slave #(
   parameter logic [63:0] ROM_ID        = 64'h2800_0000_ABCD_EF01,
   parameter int          RESET_MIN     = 480,
   parameter int          PRESENCE_WAIT = 30,
   parameter int          PRESENCE_LEN  = 120,
   parameter int          SAMPLE_POINT  = 30,
   parameter int          READ_HOLD     = 45,
   parameter int          DATA_BITS     = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   inout  wire                  bus,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 selected,
   output logic [7:0]           rom_cmd,
   output logic                 cmd_err
);

   // state     | meaning
   // IDLE      | unselected, only a master reset pulse is acted on
   // RST_LOW   | reset pulse qualified, waiting for the master to release the bus
   // PRES_WAIT | gap between bus release and presence pulse
   // PRES_DRV  | slave holds the bus low as presence pulse
   // RX_CMD    | receiving the 8-bit ROM command
   // TX_ROM    | answering 64 read slots with ROM_ID
   // RX_MATCH  | receiving 64 bits to compare against ROM_ID
   // RX_DATA   | receiving the payload
   // DONE      | payload delivered, waiting for the next reset pulse

   localparam int SR_W      = (DATA_BITS > 64) ? DATA_BITS : 64;
   localparam int BCW       = $clog2(SR_W) + 1;
   localparam int LOW_W     = $clog2(RESET_MIN + 1);
   localparam int SLOT_MAXV = ((SAMPLE_POINT > READ_HOLD) ? SAMPLE_POINT : READ_HOLD) + 1;
   localparam int SLOT_W    = $clog2(SLOT_MAXV + 1);
   localparam int TMR_W     = $clog2(((PRESENCE_LEN > PRESENCE_WAIT) ? PRESENCE_LEN : PRESENCE_WAIT) + 1);

   localparam logic [LOW_W-1:0]  LOW_TC   = LOW_W'(RESET_MIN);
   localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SLOT_MAXV);
   localparam logic [SLOT_W-1:0] SP_TC    = SLOT_W'(SAMPLE_POINT);
   localparam logic [SLOT_W-1:0] RH_TC    = SLOT_W'(READ_HOLD - 1);
   // Entry into PRES_WAIT and the drive register each cost a cycle, hence -2.
   localparam logic [TMR_W-1:0]  PW_LOAD  = TMR_W'(PRESENCE_WAIT - 2);
   localparam logic [TMR_W-1:0]  PL_LOAD  = TMR_W'(PRESENCE_LEN - 1);
   localparam logic [BCW-1:0]    BC_CMD   = BCW'(7);
   localparam logic [BCW-1:0]    BC_ROM   = BCW'(63);
   localparam logic [BCW-1:0]    BC_DATA  = BCW'(DATA_BITS - 1);

   typedef enum logic [3:0] {
      IDLE, RST_LOW, PRES_WAIT, PRES_DRV, RX_CMD, TX_ROM, RX_MATCH, RX_DATA, DONE
   } state_t;

   state_t                state, state_nx;
   logic                  bus_m, bus_s, bus_q;
   logic                  drive_low, drive_nx;
   logic [LOW_W-1:0]      low_cnt, low_cnt_nx;
   logic [SLOT_W-1:0]     slot_cnt, slot_cnt_nx;
   logic                  in_slot, in_slot_nx;
   logic [TMR_W-1:0]      timer, timer_nx;
   logic [BCW-1:0]        bit_cnt, bit_cnt_nx;
   logic [SR_W-1:0]       sr, sr_nx, sr_shift;
   logic [DATA_BITS-1:0]  data_out_nx;
   logic                  data_valid_nx, selected_nx, cmd_err_nx;
   logic [7:0]            rom_cmd_nx, cmd_byte;
   logic                  fall, slot_act, sample, rd_end, reset_det;

   assign bus = drive_low ? 1'b0 : 1'bz;

   always_ff @(posedge clk) begin
      if (reset) begin
         bus_m <= 1'b1;
         bus_s <= 1'b1;
         bus_q <= 1'b1;
      end else begin
         bus_m <= bus;
         bus_s <= bus_m;
         bus_q <= bus_s;
      end
   end

   assign fall      = bus_q & ~bus_s;
   assign slot_act  = (state == RX_CMD) || (state == TX_ROM) || (state == RX_MATCH) || (state == RX_DATA);
   assign sample    = slot_act && in_slot && !fall && (slot_cnt == SP_TC);
   assign rd_end    = in_slot && !fall && (slot_cnt == RH_TC);
   assign reset_det = (low_cnt == LOW_TC) && !bus_s && !drive_low;
   assign sr_shift  = {bus_s, sr[SR_W-1:1]};
   assign cmd_byte  = sr_shift[SR_W-1 -: 8];

   always_comb begin
      state_nx      = state;
      drive_nx      = drive_low;
      low_cnt_nx    = '0;
      slot_cnt_nx   = slot_cnt;
      in_slot_nx    = in_slot;
      timer_nx      = timer;
      bit_cnt_nx    = bit_cnt;
      sr_nx         = sr;
      data_out_nx   = data_out;
      data_valid_nx = 1'b0;
      selected_nx   = selected;
      rom_cmd_nx    = rom_cmd;
      cmd_err_nx    = 1'b0;

      if (!bus_s && !drive_low)
         low_cnt_nx = (low_cnt == LOW_TC) ? low_cnt : low_cnt + 1'b1;

      // Every falling edge (re)starts a slot, so a glitch before sampling is absorbed.
      if (slot_act && fall) begin
         slot_cnt_nx = '0;
         in_slot_nx  = 1'b1;
      end else if (in_slot && slot_cnt != SLOT_MAX) begin
         slot_cnt_nx = slot_cnt + 1'b1;
      end

      case (state)
         RST_LOW: begin
            if (bus_s) begin
               state_nx = PRES_WAIT;
               timer_nx = PW_LOAD;
            end
         end
         PRES_WAIT: begin
            if (timer == '0) begin
               state_nx = PRES_DRV;
               drive_nx = 1'b1;
               timer_nx = PL_LOAD;
            end else begin
               timer_nx = timer - 1'b1;
            end
         end
         PRES_DRV: begin
            if (timer == '0) begin
               state_nx   = RX_CMD;
               drive_nx   = 1'b0;
               bit_cnt_nx = '0;
            end else begin
               timer_nx = timer - 1'b1;
            end
         end
         RX_CMD: begin
            if (sample) begin
               sr_nx      = sr_shift;
               in_slot_nx = 1'b0;
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == BC_CMD) begin
                  rom_cmd_nx = cmd_byte;
                  bit_cnt_nx = '0;
                  case (cmd_byte)
                     8'h33:   state_nx = TX_ROM;
                     8'h55:   state_nx = RX_MATCH;
                     8'hCC: begin
                        state_nx    = RX_DATA;
                        selected_nx = 1'b1;
                     end
                     default: begin
                        state_nx   = IDLE;
                        cmd_err_nx = 1'b1;
                     end
                  endcase
               end
            end
         end
         TX_ROM: begin
            if (fall) begin
               drive_nx = ~ROM_ID[bit_cnt[5:0]];
            end else if (rd_end) begin
               drive_nx   = 1'b0;
               in_slot_nx = 1'b0;
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == BC_ROM) begin
                  state_nx    = RX_DATA;
                  selected_nx = 1'b1;
                  bit_cnt_nx  = '0;
               end
            end
         end
         RX_MATCH: begin
            if (sample) begin
               sr_nx      = sr_shift;
               in_slot_nx = 1'b0;
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == BC_ROM) begin
                  bit_cnt_nx = '0;
                  if (sr_shift[SR_W-1 -: 64] == ROM_ID) begin
                     state_nx    = RX_DATA;
                     selected_nx = 1'b1;
                  end else begin
                     state_nx   = IDLE;
                     cmd_err_nx = 1'b1;
                  end
               end
            end
         end
         RX_DATA: begin
            if (sample) begin
               sr_nx      = sr_shift;
               in_slot_nx = 1'b0;
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == BC_DATA) begin
                  data_out_nx   = sr_shift[SR_W-1 -: DATA_BITS];
                  data_valid_nx = 1'b1;
                  state_nx      = DONE;
                  bit_cnt_nx    = '0;
               end
            end
         end
         default: ;
      endcase

      if (state_nx != state)
         in_slot_nx = 1'b0;

      if (reset_det) begin
         state_nx    = RST_LOW;
         selected_nx = 1'b0;
         drive_nx    = 1'b0;
         in_slot_nx  = 1'b0;
         slot_cnt_nx = '0;
         bit_cnt_nx  = '0;
         timer_nx    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         drive_low  <= 1'b0;
         low_cnt    <= '0;
         slot_cnt   <= '0;
         in_slot    <= 1'b0;
         timer      <= '0;
         bit_cnt    <= '0;
         sr         <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         selected   <= 1'b0;
         rom_cmd    <= '0;
         cmd_err    <= 1'b0;
      end else begin
         state      <= state_nx;
         drive_low  <= drive_nx;
         low_cnt    <= low_cnt_nx;
         slot_cnt   <= slot_cnt_nx;
         in_slot    <= in_slot_nx;
         timer      <= timer_nx;
         bit_cnt    <= bit_cnt_nx;
         sr         <= sr_nx;
         data_out   <= data_out_nx;
         data_valid <= data_valid_nx;
         selected   <= selected_nx;
         rom_cmd    <= rom_cmd_nx;
         cmd_err    <= cmd_err_nx;
      end
   end

endmodule

// File: tb/tb_onewire_slave.sv
// Bench for onewire_slave: a bus master with randomized slot timing drives transactions,
// and a transaction-level model predicts selection, payload and error outcomes.
module tb_onewire_slave;

   localparam logic [63:0] ROM  = 64'h2800_0000_ABCD_EF01;
   localparam int          SLOT = 62;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_drv;
   wire         bus;
   logic [63:0] data_out;
   logic        data_valid;
   logic        selected;
   logic [7:0]  rom_cmd;
   logic        cmd_err;

   pullup pu (bus);
   assign bus = m_drv ? 1'b0 : 1'bz;

   onewire_slave dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .data_out   (data_out),
      .data_valid (data_valid),
      .selected   (selected),
      .rom_cmd    (rom_cmd),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int dv_cnt  = 0;
   int err_cnt = 0;

   always @(posedge clk) begin
      if (data_valid) dv_cnt++;
      if (cmd_err)    err_cnt++;
   end

   // transaction-level expectations
   logic [63:0] exp_data;
   logic        exp_sel;
   logic [7:0]  exp_cmd;

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_bit(input logic b);
      int low;
      low = b ? int'($urandom_range(2, 10)) : int'($urandom_range(40, 55));
      m_drv = 1'b1;
      step(low);
      m_drv = 1'b0;
      step(SLOT - low);
   endtask

   task automatic write_bits(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) write_bit(v[i]);
   endtask

   task automatic read_bit(output logic b);
      m_drv = 1'b1;
      step(4);
      m_drv = 1'b0;
      step(11);
      b = bus;
      step(SLOT - 15);
   endtask

   task automatic ow_reset(input string tag);
      int k;
      int len;
      m_drv = 1'b1;
      step(500);
      m_drv = 1'b0;
      k = 0;
      do begin
         step(1);
         k++;
      end while (bus !== 1'b0 && k < 200);
      chk_val({tag, "_pres_start"}, 64'(k), 64'd32);
      len = 0;
      while (bus === 1'b0 && len < 300) begin
         step(1);
         len++;
      end
      chk_val({tag, "_pres_len"}, 64'(len), 64'd120);
      exp_sel = 1'b0;
      step(20);
   endtask

   initial begin
      logic [63:0] rd;
      logic [63:0] pay;
      logic [63:0] mid;
      logic        b;
      int          dv0;
      int          e0;
      logic [7:0]  cmd;
      logic        ok;
      int          choice;

      exp_data = '0;
      exp_sel  = 1'b0;
      exp_cmd  = '0;
      m_drv    = 1'b0;
      reset    = 1'b1;
      step(5);
      reset = 1'b0;
      step(2);

      chk_val("rst_data_out",   data_out,   64'd0);
      chk_val("rst_data_valid", 64'(data_valid), 64'd0);
      chk_val("rst_selected",   64'(selected),   64'd0);
      chk_val("rst_rom_cmd",    64'(rom_cmd),    64'd0);
      chk_val("rst_cmd_err",    64'(cmd_err),    64'd0);
      chk_val("rst_bus_free",   64'(bus),        64'd1);

      // T1 + T2: presence, READ ROM
      ow_reset("t1");
      chk_val("t1_selected", 64'(selected), 64'd0);
      for (int i = 0; i < 8; i++) write_bit(i[0] | i[1] ? 8'h33 >> i & 1'b1 : 8'h33 >> i & 1'b1);
      rd = '0;
      for (int i = 0; i < 64; i++) begin
         read_bit(b);
         rd[i] = b;
         if (i == 31) chk_val("t2_sel_mid", 64'(selected), 64'd0);
      end
      chk_val("t2_rom_read", rd, ROM);
      chk_val("t2_selected", 64'(selected), 64'd1);
      chk_val("t2_rom_cmd",  64'(rom_cmd), 64'h33);

      // T3: SKIP ROM + fixed payload, then slots in DONE are ignored
      ow_reset("t3");
      dv0 = dv_cnt;
      write_bits(64'hCC, 8);
      write_bits(64'hDEAD_BEEF_0123_4567, 64);
      exp_data = 64'hDEAD_BEEF_0123_4567;
      chk_val("t3_data_out", data_out, exp_data);
      chk_val("t3_dv_pulses", 64'(dv_cnt - dv0), 64'd1);
      chk_val("t3_rom_cmd", 64'(rom_cmd), 64'hCC);
      chk_val("t3_selected", 64'(selected), 64'd1);
      write_bits({$urandom, $urandom}, 8);
      chk_val("t3_done_ignore", data_out, exp_data);
      chk_val("t3_done_dv", 64'(dv_cnt - dv0), 64'd1);

      // T4: MATCH ROM with bit 17 flipped
      ow_reset("t4");
      chk_val("t4_sel_cleared", 64'(selected), 64'd0);
      e0  = err_cnt;
      dv0 = dv_cnt;
      write_bits(64'h55, 8);
      write_bits(ROM ^ (64'd1 << 17), 64);
      chk_val("t4_err_pulses", 64'(err_cnt - e0), 64'd1);
      chk_val("t4_selected", 64'(selected), 64'd0);
      write_bits({$urandom, $urandom}, 64);
      chk_val("t4_data_kept", data_out, exp_data);
      chk_val("t4_dv_none", 64'(dv_cnt - dv0), 64'd0);

      // T5: unknown command, then a good MATCH ROM
      ow_reset("t5a");
      e0 = err_cnt;
      write_bits(64'hA5, 8);
      chk_val("t5_err_pulses", 64'(err_cnt - e0), 64'd1);
      chk_val("t5_rom_cmd", 64'(rom_cmd), 64'hA5);
      chk_val("t5_sel_bad", 64'(selected), 64'd0);
      ow_reset("t5b");
      e0 = err_cnt;
      write_bits(64'h55, 8);
      write_bits(ROM, 64);
      chk_val("t5_sel_match", 64'(selected), 64'd1);
      chk_val("t5_err_none", 64'(err_cnt - e0), 64'd0);
      pay = {$urandom, $urandom};
      write_bits(pay, 64);
      exp_data = pay;
      chk_val("t5_data_out", data_out, exp_data);

      // T6: reset pulse in the middle of a payload
      ow_reset("t6a");
      dv0 = dv_cnt;
      write_bits(64'hCC, 8);
      mid = {$urandom, $urandom};
      write_bits(mid, 30);
      ow_reset("t6b");
      chk_val("t6_selected", 64'(selected), 64'd0);
      chk_val("t6_data_kept", data_out, exp_data);
      chk_val("t6_dv_none", 64'(dv_cnt - dv0), 64'd0);

      // randomized transactions against the model
      for (int it = 0; it < 2; it++) begin
         ow_reset("rnd");
         choice = int'($urandom_range(0, 3));
         pay    = {$urandom, $urandom};
         e0     = err_cnt;
         dv0    = dv_cnt;
         case (choice)
            0: cmd = 8'hCC;
            1, 2: cmd = 8'h55;
            default: begin
               do cmd = 8'($urandom); while (cmd == 8'h33 || cmd == 8'hCC || cmd == 8'h55);
            end
         endcase
         write_bits(64'(cmd), 8);
         if (cmd == 8'h55)
            write_bits((choice == 2) ? ROM ^ (64'd1 << $urandom_range(0, 63)) : ROM, 64);
         write_bits(pay, 64);
         ok       = (cmd == 8'hCC) || (cmd == 8'h55 && choice == 1);
         exp_cmd  = cmd;
         exp_sel  = ok;
         if (ok) exp_data = pay;
         chk_val("rnd_rom_cmd",  64'(rom_cmd), 64'(exp_cmd));
         chk_val("rnd_selected", 64'(selected), 64'(exp_sel));
         chk_val("rnd_data_out", data_out, exp_data);
         chk_val("rnd_dv",       64'(dv_cnt - dv0), ok ? 64'd1 : 64'd0);
         chk_val("rnd_err",      64'(err_cnt - e0), ok ? 64'd0 : 64'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
